// File: rtl/rf_dump_uart_if.sv
// Debug-port bundle between the register-file dumper and its surroundings.
// The slave side is the dumper; the master side is the board top / register file.
interface rf_dump_uart_if;
    logic        start;
    logic [31:0] reg_data;
    logic [4:0]  reg_sel;
    logic        txd;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output reg_data,
        input  reg_sel,
        input  txd,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  reg_data,
        output reg_sel,
        output txd,
        output busy,
        output done
    );
endinterface

// File: rtl/rf_dump_uart.sv
// Register-file dumper: walks reg_sel 0..31, captures each word and streams a sync
// byte plus 128 payload bytes (MSB byte first) over a UART 8N1 transmitter.
module rf_dump_uart #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input logic           clk,
    input logic           rst,
    rf_dump_uart_if.slave dbg
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] NEXT = 3'd4;
    localparam logic [2:0] FIN  = 3'd5;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  state_q, state_d;
    logic [4:0]  reg_sel_q, reg_sel_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        bit_end;
    logic        byte_end;
    logic        launch;
    logic [7:0]  launch_byte;

    assign bit_end  = (bit_cnt_q == BIT_LAST);
    assign byte_end = bit_end && (bit_idx_q == 4'd9);

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Next-state logic: FSM sequencing plus the bit-level serialiser.
    always_comb begin
        state_d     = state_q;
        reg_sel_d   = reg_sel_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        txd_d       = txd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        launch      = 1'b0;
        launch_byte = SYNC_BYTE;

        // Serialiser: bit index 0 is the start bit, 1..8 data, 9 stop. The shift register
        // fills with ones so the bit after the last data bit is automatically the stop bit.
        if (state_q == HDR || state_q == SEND) begin
            if (bit_end) begin
                bit_cnt_d = 16'd0;
                if (bit_idx_q != 4'd9) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b1, shift_q[7:1]};
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 16'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (dbg.start) begin
                    state_d     = HDR;
                    busy_d      = 1'b1;
                    reg_sel_d   = 5'd0;
                    launch      = 1'b1;
                    launch_byte = SYNC_BYTE;
                end
            end
            HDR: begin
                if (byte_end) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Capture and start the first byte on the same edge to keep the gap short.
                word_d      = dbg.reg_data;
                byte_idx_d  = 2'd0;
                launch      = 1'b1;
                launch_byte = dbg.reg_data[31:24];
                state_d     = SEND;
            end
            SEND: begin
                if (byte_end) begin
                    if (byte_idx_q == 2'd3) begin
                        state_d = NEXT;
                    end else begin
                        byte_idx_d  = byte_idx_q + 2'd1;
                        launch      = 1'b1;
                        launch_byte = word_byte(word_q, byte_idx_q + 2'd1);
                    end
                end
            end
            NEXT: begin
                if (reg_sel_q == 5'd31) begin
                    state_d = FIN;
                end else begin
                    reg_sel_d = reg_sel_q + 5'd1;
                    state_d   = LOAD;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            bit_cnt_d = 16'd0;
            bit_idx_d = 4'd0;
            txd_d     = 1'b0;
            shift_d   = launch_byte;
        end
    end

    // State registers with synchronous reset; reset aborts any dump in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            reg_sel_q  <= 5'd0;
            word_q     <= 32'd0;
            byte_idx_q <= 2'd0;
            bit_cnt_q  <= 16'd0;
            bit_idx_q  <= 4'd0;
            shift_q    <= 8'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_sel_q  <= reg_sel_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dbg.reg_sel = reg_sel_q;
    assign dbg.txd     = txd_q;
    assign dbg.busy    = busy_q;
    assign dbg.done    = done_q;
endmodule

// File: tb/tb_rf_dump_uart.sv
// Bench for rf_dump_uart: emulated register file, UART decoder and a byte-stream model.
module tb_rf_dump_uart;
    localparam int CPB    = 4;
    localparam int NBYTES = 129;
    localparam int DMIN   = 1290 * CPB;
    localparam int DMAX   = 1290 * CPB + 3 * 129 + 66;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_dump_uart_if dif();

    rf_dump_uart #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .dbg (dif)
    );

    logic [31:0] rf [32];
    logic [31:0] exp_regs [32];
    assign dif.reg_data = (dif.reg_sel == 5'd0) ? 32'h0 : rf[dif.reg_sel];

    int tests = 0;
    int failures = 0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int framing_err = 0;
    int done_cnt = 0;
    int done_busy_bad = 0;
    int sel_vals, sel_step_bad, sel_hold_min;

    // UART 8N1 decoder, sampling mid-bit on negedges.
    initial begin : uart_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (dif.txd === 1'b0) begin
                @(negedge clk);
                if (dif.txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = dif.txd;
                    end
                    repeat (CPB) @(negedge clk);
                    if (dif.txd !== 1'b1) framing_err++;
                    rx_q.push_back(b);
                end
            end
        end
    end

    // done pulses, and whether busy dropped in the cycle done rose.
    initial begin : done_mon
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (dif.done === 1'b1) begin
                done_cnt++;
                if (!(prev_busy === 1'b1 && dif.busy === 1'b0)) done_busy_bad++;
            end
            prev_busy = dif.busy;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected stream: sync byte, then each register's word big-endian; r0 reads as zero.
    task automatic build_exp();
        logic [31:0] v;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < 32; r++) begin
            v = (r == 0) ? 32'h0 : exp_regs[r];
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'(v >> (8 * b)));
        end
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 32; i++) begin
            rf[i] = $urandom();
            exp_regs[i] = rf[i];
        end
    endtask

    // Pulse start and wait for done; optional second start pulse and live write.
    task automatic run_dump(input int kick_at, input bit live, output int cyc, output bit tmo);
        int cur;
        int hold;
        bit written;
        cur = -1;
        hold = 0;
        written = 1'b0;
        rx_q.delete();
        framing_err = 0;
        sel_vals = 0;
        sel_step_bad = 0;
        sel_hold_min = 1 << 30;
        tmo = 1'b1;
        cyc = 0;
        @(negedge clk);
        dif.start = 1'b1;
        for (int k = 1; k <= 8000; k++) begin
            @(negedge clk);
            if (k == 1) dif.start = 1'b0;
            if (k == kick_at) dif.start = 1'b1;
            else if (k == kick_at + 1) dif.start = 1'b0;
            if (live && !written && dif.reg_sel == 5'd3) begin
                rf[5] = 32'hCAFEF00D;
                rf[2] = ~rf[2];
                written = 1'b1;
            end
            if (int'(dif.reg_sel) != cur) begin
                if (cur >= 0) begin
                    if (int'(dif.reg_sel) != cur + 1) sel_step_bad++;
                    if (hold < sel_hold_min) sel_hold_min = hold;
                end
                cur = int'(dif.reg_sel);
                hold = 1;
                sel_vals++;
            end else begin
                hold++;
            end
            if (dif.done === 1'b1) begin
                cyc = k - 1;
                tmo = 1'b0;
                break;
            end
        end
        if (hold < sel_hold_min) sel_hold_min = hold;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.start = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (dif.txd !== 1'b1) begin failures++;
            $display("FAIL reset_txd: got %b, expected 1", dif.txd); end
        tests++; if (dif.busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy: got %b, expected 0", dif.busy); end
        tests++; if (dif.done !== 1'b0) begin failures++;
            $display("FAIL reset_done: got %b, expected 0", dif.done); end
        tests++; if (dif.reg_sel !== 5'd0) begin failures++;
            $display("FAIL reset_reg_sel: got %0d, expected 0", dif.reg_sel); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_dump();
        int cyc;
        bit tmo;
        int d0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[0] = $urandom() | 32'h1;
        rf[1] = 32'h12345678;
        rf[31] = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) exp_regs[i] = rf[i];
        build_exp();
        d0 = done_cnt;
        run_dump(0, 1'b0, cyc, tmo);
        tests++; if (tmo) begin failures++; $display("FAIL basic_timeout: no done"); end
        tests++; if (cyc < DMIN || cyc > DMAX) begin failures++;
            $display("FAIL basic_duration: got %0d, expected %0d..%0d", cyc, DMIN, DMAX); end
        tests++; if (rx_q.size() != NBYTES) begin failures++;
            $display("FAIL basic_count: got %0d, expected %0d", rx_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
            tests++; if (rx_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL basic_byte%0d: got %02h, expected %02h", i, rx_q[i], exp_q[i]); end
        end
        tests++; if (framing_err != 0) begin failures++;
            $display("FAIL basic_framing: got %0d errors, expected 0", framing_err); end
        tests++; if (done_cnt - d0 != 1) begin failures++;
            $display("FAIL basic_done_pulses: got %0d, expected 1", done_cnt - d0); end
        tests++; if (done_busy_bad != 0) begin failures++;
            $display("FAIL basic_busy_at_done: got %0d bad, expected 0", done_busy_bad); end
        tests++; if (dif.reg_sel !== 5'd31) begin failures++;
            $display("FAIL basic_reg_sel_after: got %0d, expected 31", dif.reg_sel); end
    endtask

    task automatic test_bit_timing();
        logic samp [64];
        logic expw [40];
        logic [7:0] sb;
        int k0;
        bit seen;
        sb = 8'hA5;
        for (int j = 0; j < 40; j++) begin
            if (j < 4) expw[j] = 1'b0;
            else if (j < 36) expw[j] = sb[(j - 4) / 4];
            else expw[j] = 1'b1;
        end
        randomize_rf();
        @(negedge clk);
        dif.start = 1'b1;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (k == 1) dif.start = 1'b0;
            samp[k] = dif.txd;
        end
        k0 = 1;
        seen = 1'b0;
        for (int k = 1; k < 20; k++) if (!seen && samp[k] === 1'b0) begin k0 = k; seen = 1'b1; end
        tests++; if (!seen || k0 > 3) begin failures++;
            $display("FAIL timing_start_offset: got %0d, expected 1..3", seen ? k0 : -1); end
        for (int j = 0; j < 40; j++) begin
            tests++; if (samp[k0 + j] !== expw[j]) begin failures++;
                $display("FAIL timing_cycle%0d: got %b, expected %b", j, samp[k0 + j], expw[j]); end
        end
        seen = 1'b0;
        for (int k = 0; k < 8000 && !seen; k++) begin
            @(negedge clk);
            if (dif.done === 1'b1) seen = 1'b1;
        end
        tests++; if (!seen) begin failures++; $display("FAIL timing_done: no done"); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int cyc;
        bit tmo;
        int d0;
        randomize_rf();
        build_exp();
        d0 = done_cnt;
        run_dump(100, 1'b0, cyc, tmo);
        repeat (1000) @(negedge clk);
        tests++; if (tmo) begin failures++; $display("FAIL busy_start_timeout: no done"); end
        tests++; if (rx_q.size() != NBYTES) begin failures++;
            $display("FAIL busy_start_count: got %0d, expected %0d", rx_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
            tests++; if (rx_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL busy_start_byte%0d: got %02h, expected %02h", i, rx_q[i],
                         exp_q[i]); end
        end
        tests++; if (done_cnt - d0 != 1) begin failures++;
            $display("FAIL busy_start_done_pulses: got %0d, expected 1", done_cnt - d0); end
        tests++; if (dif.busy !== 1'b0) begin failures++;
            $display("FAIL busy_start_requeued: busy got %b, expected 0", dif.busy); end
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        bit tmo;
        bit hit;
        int d0;
        randomize_rf();
        rx_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 8000 && !hit; k++) begin
            if (rx_q.size() >= 40 && dif.txd === 1'b0) hit = 1'b1;
            else @(negedge clk);
        end
        tests++; if (!hit) begin failures++; $display("FAIL rst_mid_reach_byte40: not reached"); end
        rst = 1'b1;
        dif.start = 1'b1;
        @(negedge clk);
        tests++; if (dif.txd !== 1'b1) begin failures++;
            $display("FAIL rst_mid_txd: got %b, expected 1", dif.txd); end
        tests++; if (dif.busy !== 1'b0) begin failures++;
            $display("FAIL rst_mid_busy: got %b, expected 0", dif.busy); end
        tests++; if (dif.reg_sel !== 5'd0) begin failures++;
            $display("FAIL rst_mid_reg_sel: got %0d, expected 0", dif.reg_sel); end
        rst = 1'b0;
        dif.start = 1'b0;
        repeat (100) @(negedge clk);
        tests++; if (dif.busy !== 1'b0) begin failures++;
            $display("FAIL rst_start_ignored: busy got %b, expected 0", dif.busy); end
        tests++; if (done_cnt != d0) begin failures++;
            $display("FAIL rst_mid_no_done: got %0d pulses, expected 0", done_cnt - d0); end
        randomize_rf();
        build_exp();
        run_dump(0, 1'b0, cyc, tmo);
        tests++; if (tmo) begin failures++; $display("FAIL rst_redo_timeout: no done"); end
        tests++; if (rx_q.size() != NBYTES) begin failures++;
            $display("FAIL rst_redo_count: got %0d, expected %0d", rx_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
            tests++; if (rx_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL rst_redo_byte%0d: got %02h, expected %02h", i, rx_q[i], exp_q[i]); end
        end
        tests++; if (done_cnt - d0 != 1) begin failures++;
            $display("FAIL rst_redo_done_pulses: got %0d, expected 1", done_cnt - d0); end
    endtask

    task automatic test_live_write();
        int cyc;
        bit tmo;
        randomize_rf();
        exp_regs[5] = 32'hCAFEF00D;  // written before r5 is captured; r2 already sent
        build_exp();
        run_dump(0, 1'b1, cyc, tmo);
        tests++; if (tmo) begin failures++; $display("FAIL live_timeout: no done"); end
        tests++; if (rx_q.size() != NBYTES) begin failures++;
            $display("FAIL live_count: got %0d, expected %0d", rx_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
            tests++; if (rx_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL live_byte%0d: got %02h, expected %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reg_sel_seq();
        int cyc;
        bit tmo;
        randomize_rf();
        build_exp();
        run_dump(0, 1'b0, cyc, tmo);
        tests++; if (tmo) begin failures++; $display("FAIL sel_timeout: no done"); end
        tests++; if (sel_vals != 32) begin failures++;
            $display("FAIL sel_values: got %0d, expected 32", sel_vals); end
        tests++; if (sel_step_bad != 0) begin failures++;
            $display("FAIL sel_steps: got %0d bad steps, expected 0", sel_step_bad); end
        tests++; if (sel_hold_min < 40 * CPB) begin failures++;
            $display("FAIL sel_hold: got %0d, expected >= %0d", sel_hold_min, 40 * CPB); end
        tests++; if (rx_q.size() != NBYTES) begin failures++;
            $display("FAIL sel_count: got %0d, expected %0d", rx_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
            tests++; if (rx_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL sel_byte%0d: got %02h, expected %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        dif.start = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        test_reset();
        test_basic_dump();
        test_bit_timing();
        test_start_while_busy();
        test_reset_mid_dump();
        test_live_write();
        test_reg_sel_seq();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
